// File: rtl/mat_ram_ctrl_pkg.sv
// mat_ram_ctrl_pkg
// Shared constants and the FSM state type for the matrix RAM sequencer.
//   WORD_LEN   : bits per matrix element
//   MATRIX_DIM : matrix side, N = MATRIX_DIM*MATRIX_DIM words
//   ADDR_BITS  : RAM address width (N must fit)
//   RD_LAT     : RAM edges from address sample to valid q (>= 1)
package mat_ram_ctrl_pkg;

    localparam int WORD_LEN   = 32;
    localparam int MATRIX_DIM = 8;
    localparam int ADDR_BITS  = 7;
    localparam int RD_LAT     = 1;
    localparam int N          = MATRIX_DIM * MATRIX_DIM;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_RD_ADDR = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_RD_OUT  = 3'd4
    } state_t;

endpackage

// File: rtl/mat_ram_ctrl.sv
// mat_ram_ctrl
// Sequencer owning the single port of a matrix RAM. A load phase streams one
// N-word matrix into addresses 0..N-1; a read phase fetches one full row per
// RAM access and offers it downstream over valid/ready.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_load, cmd_read         start pulses (accepted only in IDLE)
//   busy                       high whenever not IDLE
//   load_done, read_done       1-cycle completion pulses
//   cmd_err                    1-cycle pulse when a command was dropped
//   in_data/in_valid/in_ready  load word stream
//   row_data/row_idx/row_valid/row_ready  row output stream
//   ram_data/ram_addr/ram_we/ram_q        RAM port
module mat_ram_ctrl
    import mat_ram_ctrl_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cmd_load,
    input  logic                           cmd_read,
    output logic                           busy,
    output logic                           load_done,
    output logic                           read_done,
    output logic                           cmd_err,
    input  logic [WORD_LEN-1:0]            in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [WORD_LEN*MATRIX_DIM-1:0] row_data,
    output logic [$clog2(MATRIX_DIM)-1:0]  row_idx,
    output logic                           row_valid,
    input  logic                           row_ready,
    output logic [WORD_LEN-1:0]            ram_data,
    output logic [ADDR_BITS-1:0]           ram_addr,
    output logic                           ram_we,
    input  logic [WORD_LEN*MATRIX_DIM-1:0] ram_q
);

    localparam int RC_W  = $clog2(MATRIX_DIM);
    localparam int LAT_W = $clog2(RD_LAT + 1);
    localparam int ROW_W = WORD_LEN * MATRIX_DIM;

    state_t               state_reg, state_next;
    logic [ADDR_BITS-1:0] wc_reg, wc_next;
    logic [RC_W-1:0]      rc_reg, rc_next;
    logic [LAT_W-1:0]     lat_reg, lat_next;
    logic [ROW_W-1:0]     row_data_reg, row_data_next;
    logic [RC_W-1:0]      row_idx_reg, row_idx_next;
    logic                 row_valid_reg, row_valid_next;
    logic                 load_done_reg, load_done_next;
    logic                 read_done_reg, read_done_next;
    logic                 cmd_err_reg, cmd_err_next;
    logic [ADDR_BITS-1:0] row_base;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            wc_reg        <= '0;
            rc_reg        <= '0;
            lat_reg       <= '0;
            row_data_reg  <= '0;
            row_idx_reg   <= '0;
            row_valid_reg <= 1'b0;
            load_done_reg <= 1'b0;
            read_done_reg <= 1'b0;
            cmd_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wc_reg        <= wc_next;
            rc_reg        <= rc_next;
            lat_reg       <= lat_next;
            row_data_reg  <= row_data_next;
            row_idx_reg   <= row_idx_next;
            row_valid_reg <= row_valid_next;
            load_done_reg <= load_done_next;
            read_done_reg <= read_done_next;
            cmd_err_reg   <= cmd_err_next;
        end
    end

    // First word address of the current row.
    assign row_base = ADDR_BITS'(rc_reg) * ADDR_BITS'(MATRIX_DIM);

    always_comb begin
        state_next     = state_reg;
        wc_next        = wc_reg;
        rc_next        = rc_reg;
        lat_next       = lat_reg;
        row_data_next  = row_data_reg;
        row_idx_next   = row_idx_reg;
        row_valid_next = row_valid_reg;
        load_done_next = 1'b0;
        read_done_next = 1'b0;
        // Any command arriving while a phase is running is dropped.
        cmd_err_next   = (state_reg != ST_IDLE) && (cmd_load || cmd_read);
        in_ready       = 1'b0;
        ram_we         = 1'b0;
        ram_addr       = '0;
        ram_data       = '0;

        unique case (state_reg)
            ST_IDLE: begin
                if (cmd_load) begin
                    // Load has priority; a simultaneous read is reported dropped.
                    state_next   = ST_LOAD;
                    wc_next      = '0;
                    cmd_err_next = cmd_read;
                end else if (cmd_read) begin
                    state_next = ST_RD_ADDR;
                    rc_next    = '0;
                end
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                ram_we   = in_valid;
                ram_addr = wc_reg;
                ram_data = in_data;
                if (in_valid) begin
                    if (wc_reg == ADDR_BITS'(N - 1)) begin
                        state_next     = ST_IDLE;
                        wc_next        = '0;
                        load_done_next = 1'b1;
                    end else begin
                        wc_next = wc_reg + ADDR_BITS'(1);
                    end
                end
            end
            ST_RD_ADDR: begin
                ram_addr   = row_base;
                state_next = ST_RD_WAIT;
                lat_next   = LAT_W'(RD_LAT);
            end
            ST_RD_WAIT: begin
                // Address stays on the port until q for it has been captured.
                ram_addr = row_base;
                if (lat_reg <= LAT_W'(1)) begin
                    lat_next       = '0;
                    row_data_next  = ram_q;
                    row_idx_next   = rc_reg;
                    row_valid_next = 1'b1;
                    state_next     = ST_RD_OUT;
                end else begin
                    lat_next = lat_reg - LAT_W'(1);
                end
            end
            ST_RD_OUT: begin
                ram_addr = row_base;
                if (row_ready) begin
                    row_valid_next = 1'b0;
                    if (rc_reg == RC_W'(MATRIX_DIM - 1)) begin
                        state_next     = ST_IDLE;
                        read_done_next = 1'b1;
                    end else begin
                        rc_next    = rc_reg + RC_W'(1);
                        state_next = ST_RD_ADDR;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign busy      = (state_reg != ST_IDLE);
    assign load_done = load_done_reg;
    assign read_done = read_done_reg;
    assign cmd_err   = cmd_err_reg;
    assign row_data  = row_data_reg;
    assign row_idx   = row_idx_reg;
    assign row_valid = row_valid_reg;

endmodule

// File: tb/tb_mat_ram_ctrl.sv
// tb_mat_ram_ctrl
// Self-checking bench for mat_ram_ctrl with a behavioural RAM behind it.
// The reference model is the matrix itself: word i of a load lands at
// address i, and row r of a read is words r*MATRIX_DIM .. r*MATRIX_DIM+DIM-1.
module tb_mat_ram_ctrl;
    import mat_ram_ctrl_pkg::*;

    localparam int ROW_W = WORD_LEN * MATRIX_DIM;
    localparam int RC_W  = $clog2(MATRIX_DIM);
    localparam int ROW_CYC = 2 + RD_LAT;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 cmd_load = 1'b0;
    logic                 cmd_read = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 row_ready = 1'b0;
    logic [WORD_LEN-1:0]  in_data = '0;
    logic                 busy, load_done, read_done, cmd_err, in_ready;
    logic [ROW_W-1:0]     row_data;
    logic [RC_W-1:0]      row_idx;
    logic                 row_valid;
    logic [WORD_LEN-1:0]  ram_data;
    logic [ADDR_BITS-1:0] ram_addr;
    logic                 ram_we;
    logic [ROW_W-1:0]     ram_q;

    int pass_cnt = 0;
    int total_cnt = 0;

    mat_ram_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_load  (cmd_load),
        .cmd_read  (cmd_read),
        .busy      (busy),
        .load_done (load_done),
        .read_done (read_done),
        .cmd_err   (cmd_err),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .row_data  (row_data),
        .row_idx   (row_idx),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .ram_data  (ram_data),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_q     (ram_q)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM: row-wide read, RD_LAT edges of latency.
    logic [WORD_LEN-1:0] mem [2**ADDR_BITS];
    logic [ROW_W-1:0]    q_pipe [RD_LAT];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_data;
        for (int k = 0; k < MATRIX_DIM; k++)
            q_pipe[0][k*WORD_LEN +: WORD_LEN] <= mem[ADDR_BITS'(int'(ram_addr) + k)];
        for (int s = 1; s < RD_LAT; s++) q_pipe[s] <= q_pipe[s-1];
    end
    assign ram_q = q_pipe[RD_LAT-1];

    // Bus monitor.
    logic [ADDR_BITS-1:0] log_addr [$];
    logic [WORD_LEN-1:0]  log_data [$];
    int we_bad = 0;
    int cmd_err_cnt = 0;
    int row_valid_cnt = 0;
    always @(posedge clk) begin
        if (rst_n) begin
            if (ram_we) begin
                log_addr.push_back(ram_addr);
                log_data.push_back(ram_data);
            end
            if (ram_we && !in_valid) we_bad++;
            if (cmd_err) cmd_err_cnt++;
            if (row_valid) row_valid_cnt++;
        end
    end

    // Reference model state.
    logic [WORD_LEN-1:0] ref_mem [N];
    logic [WORD_LEN-1:0] load_words [N];
    int load_cycles;

    function automatic logic [ROW_W-1:0] exp_row(input int r);
        logic [ROW_W-1:0] v;
        v = '0;
        for (int k = 0; k < MATRIX_DIM; k++) v[k*WORD_LEN +: WORD_LEN] = ref_mem[r*MATRIX_DIM + k];
        return v;
    endfunction

    // Number of logged writes that differ from "word i at address i".
    function automatic int bad_writes();
        int b;
        b = 0;
        for (int i = 0; i < log_addr.size(); i++)
            if (log_addr[i] !== ADDR_BITS'(i) || log_data[i] !== load_words[i]) b++;
        return b;
    endfunction

    // Drives a load (optionally with its command) and feeds stop_at words.
    // Returns at the negedge following the edge that accepted the last word.
    task automatic do_load(input bit send_cmd, input bit toggle, input int stop_at);
        int  idx;
        int  cyc;
        bit  drove;
        idx = 0; cyc = 0; drove = 1'b0;
        log_addr.delete(); log_data.delete(); we_bad = 0;
        if (send_cmd) begin
            @(negedge clk); cmd_load = 1'b1;
            @(negedge clk); cmd_load = 1'b0;
        end
        while (cyc < 1000) begin
            if (drove) begin
                ref_mem[idx] = load_words[idx];
                idx++;
            end
            if (idx == stop_at) break;
            drove    = toggle ? (cyc % 2 == 0) : 1'b1;
            in_valid = drove;
            in_data  = drove ? load_words[idx] : WORD_LEN'($urandom());
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        load_cycles = cyc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        total_cnt++;
        if ({busy, load_done, read_done, cmd_err, in_ready, row_valid, ram_we} !== 7'b0) begin
            $display("FAIL reset_flags: got busy=%b ld=%b rd=%b err=%b ir=%b rv=%b we=%b, required all 0",
                     busy, load_done, read_done, cmd_err, in_ready, row_valid, ram_we);
        end else pass_cnt++;
        total_cnt++;
        if (row_data !== '0 || row_idx !== '0 || ram_addr !== '0 || ram_data !== '0) begin
            $display("FAIL reset_buses: got row_data=%h row_idx=%0d ram_addr=%0d ram_data=%h, required 0",
                     row_data, row_idx, ram_addr, ram_data);
        end else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            $display("FAIL idle_after_reset: got busy=%b in_ready=%b, required 0 0", busy, in_ready);
        end else pass_cnt++;
        $display("test_reset done");
    endtask

    task automatic test_load_full();
        for (int i = 0; i < N; i++) load_words[i] = WORD_LEN'(i);
        do_load(1'b1, 1'b0, N);
        total_cnt++;
        if (load_done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
            $display("FAIL load_full_done: got load_done=%b busy=%b in_ready=%b, required 1 0 0",
                     load_done, busy, in_ready);
        end else pass_cnt++;
        total_cnt++;
        if (load_cycles !== N) begin
            $display("FAIL load_full_cycles: got %0d cycles, required %0d", load_cycles, N);
        end else pass_cnt++;
        total_cnt++;
        if (log_addr.size() !== N || bad_writes() !== 0) begin
            $display("FAIL load_full_writes: got %0d writes with %0d bad, required %0d with 0 bad",
                     log_addr.size(), bad_writes(), N);
        end else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (load_done !== 1'b0) begin
            $display("FAIL load_done_pulse: got load_done=%b one cycle later, required 0", load_done);
        end else pass_cnt++;
        $display("test_load_full done: %0d writes in %0d cycles", log_addr.size(), load_cycles);
    endtask

    task automatic test_load_toggle();
        for (int i = 0; i < N; i++) load_words[i] = WORD_LEN'($urandom());
        do_load(1'b1, 1'b1, N);
        total_cnt++;
        if (load_done !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL load_toggle_done: got load_done=%b busy=%b, required 1 0", load_done, busy);
        end else pass_cnt++;
        total_cnt++;
        if (log_addr.size() !== N || bad_writes() !== 0) begin
            $display("FAIL load_toggle_writes: got %0d writes with %0d bad, required %0d with 0 bad",
                     log_addr.size(), bad_writes(), N);
        end else pass_cnt++;
        total_cnt++;
        if (we_bad !== 0 || load_cycles !== 2*N-1) begin
            $display("FAIL load_toggle_gaps: got %0d writes without valid, %0d cycles, required 0, %0d",
                     we_bad, load_cycles, 2*N-1);
        end else pass_cnt++;
        $display("test_load_toggle done: %0d writes in %0d cycles", log_addr.size(), load_cycles);
    endtask

    task automatic test_read(input int stall_row, input int stall_cycles, input string tag);
        int r;
        int cyc;
        int last_hs;
        int exp_cyc;
        r = 0; cyc = 0; last_hs = 0; exp_cyc = ROW_CYC;
        @(negedge clk); row_ready = 1'b1; cmd_read = 1'b1;
        @(negedge clk); cmd_read = 1'b0; cyc = 1;
        total_cnt++;
        if (busy !== 1'b1 || ram_we !== 1'b0) begin
            $display("FAIL %s_start: got busy=%b ram_we=%b, required 1 0", tag, busy, ram_we);
        end else pass_cnt++;
        while (r < MATRIX_DIM && cyc < 1000) begin
            if (row_valid) begin
                total_cnt++;
                if (cyc !== exp_cyc || row_idx !== RC_W'(r) || row_data !== exp_row(r)
                    || ram_addr !== ADDR_BITS'(r*MATRIX_DIM)) begin
                    $display("FAIL %s_row%0d: got cyc=%0d idx=%0d addr=%0d data=%h, required cyc=%0d idx=%0d addr=%0d data=%h",
                             tag, r, cyc, row_idx, ram_addr, row_data, exp_cyc, r, r*MATRIX_DIM, exp_row(r));
                end else pass_cnt++;
                if (r == stall_row) begin
                    row_ready = 1'b0;
                    for (int s = 0; s < stall_cycles; s++) begin
                        @(negedge clk); cyc++;
                        if (s == stall_cycles - 1) row_ready = 1'b1;
                        total_cnt++;
                        if (row_valid !== 1'b1 || row_idx !== RC_W'(r) || row_data !== exp_row(r)
                            || ram_addr !== ADDR_BITS'(r*MATRIX_DIM)) begin
                            $display("FAIL %s_stall%0d: got valid=%b idx=%0d addr=%0d data=%h, required 1 %0d %0d %h",
                                     tag, s, row_valid, row_idx, ram_addr, row_data, r, r*MATRIX_DIM, exp_row(r));
                        end else pass_cnt++;
                    end
                end
                $display("%s row %0d seen at cycle %0d", tag, r, cyc);
                last_hs = cyc;
                exp_cyc = cyc + ROW_CYC;
                r++;
            end
            @(negedge clk); cyc++;
        end
        total_cnt++;
        if (r !== MATRIX_DIM || read_done !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL %s_done: got rows=%0d read_done=%b busy=%b, required %0d 1 0",
                     tag, r, read_done, busy, MATRIX_DIM);
        end else pass_cnt++;
        total_cnt++;
        if (last_hs !== MATRIX_DIM*ROW_CYC + stall_cycles) begin
            $display("FAIL %s_length: got last handshake at cycle %0d, required %0d",
                     tag, last_hs, MATRIX_DIM*ROW_CYC + stall_cycles);
        end else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (read_done !== 1'b0) begin
            $display("FAIL %s_done_pulse: got read_done=%b, required 0", tag, read_done);
        end else pass_cnt++;
    endtask

    task automatic test_cmd_conflict();
        for (int i = 0; i < N; i++) load_words[i] = WORD_LEN'($urandom());
        @(negedge clk);
        cmd_err_cnt = 0; row_valid_cnt = 0;
        cmd_load = 1'b1; cmd_read = 1'b1;
        @(negedge clk);
        cmd_load = 1'b0; cmd_read = 1'b0;
        total_cnt++;
        if (cmd_err !== 1'b1 || in_ready !== 1'b1) begin
            $display("FAIL conflict_first: got cmd_err=%b in_ready=%b, required 1 1", cmd_err, in_ready);
        end else pass_cnt++;
        cmd_read = 1'b1;
        @(negedge clk);
        cmd_read = 1'b0;
        total_cnt++;
        if (cmd_err !== 1'b1 || in_ready !== 1'b1) begin
            $display("FAIL conflict_in_load: got cmd_err=%b in_ready=%b, required 1 1", cmd_err, in_ready);
        end else pass_cnt++;
        do_load(1'b0, 1'b0, N);
        total_cnt++;
        if (cmd_err_cnt !== 2 || row_valid_cnt !== 0 || load_done !== 1'b1) begin
            $display("FAIL conflict_counts: got err pulses=%0d row_valid cycles=%0d load_done=%b, required 2 0 1",
                     cmd_err_cnt, row_valid_cnt, load_done);
        end else pass_cnt++;
        total_cnt++;
        if (log_addr.size() !== N || bad_writes() !== 0) begin
            $display("FAIL conflict_writes: got %0d writes with %0d bad, required %0d with 0 bad",
                     log_addr.size(), bad_writes(), N);
        end else pass_cnt++;
        $display("test_cmd_conflict done: %0d cmd_err pulses", cmd_err_cnt);
    endtask

    task automatic test_reset_mid_load();
        for (int i = 0; i < N; i++) load_words[i] = WORD_LEN'($urandom());
        do_load(1'b1, 1'b0, 20);
        total_cnt++;
        if (log_addr.size() !== 20 || busy !== 1'b1) begin
            $display("FAIL partial_load: got %0d writes busy=%b, required 20 1", log_addr.size(), busy);
        end else pass_cnt++;
        in_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({busy, load_done, read_done, cmd_err, in_ready, row_valid, ram_we} !== 7'b0
            || ram_addr !== '0 || ram_data !== '0 || row_data !== '0 || row_idx !== '0) begin
            $display("FAIL mid_reset_outputs: got busy=%b ir=%b we=%b addr=%0d data=%h rv=%b, required all 0",
                     busy, in_ready, ram_we, ram_addr, ram_data, row_valid);
        end else pass_cnt++;
        in_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) load_words[i] = WORD_LEN'($urandom());
        do_load(1'b1, 1'b0, N);
        total_cnt++;
        if (load_done !== 1'b1 || log_addr.size() !== N || bad_writes() !== 0) begin
            $display("FAIL reload_writes: got load_done=%b %0d writes %0d bad, required 1 %0d 0",
                     load_done, log_addr.size(), bad_writes(), N);
        end else pass_cnt++;
        $display("test_reset_mid_load done");
    endtask

    initial begin
        test_reset();
        test_load_full();
        test_read(-1, 0, "read_full");
        test_read(2, 5, "read_stall");
        test_load_toggle();
        test_read(-1, 0, "read_toggle");
        test_cmd_conflict();
        test_read(-1, 0, "read_conflict");
        test_reset_mid_load();
        test_read(-1, 0, "read_reload");
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, passed %0d of %0d", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

endmodule
